branch_pred_table: RTL and testbench

Parametrised dynamic branch predictor: a table of saturating counters indexed by PC, optionally XOR-hashed with a global history register (gshare). It sits beside the fetch/decode stage: it gives a combinational taken/not-taken decision for the current branch and takes resolved-branch updates from execute. It also keeps a saturating mispredict counter for performance monitoring.

---
 rtl/bp_pkg.sv | 28 ++
 rtl/bp_sat_counter.sv | 26 ++
 rtl/branch_pred_table.sv | 91 +++++++++
 tb/tb_branch_pred_table.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types, constants and the saturating-step helper for the branch predictor.
package bp_pkg;

  // Encoding of branch_occr. Bit 1 set means "use the table"; both values
  // with bit 1 set behave identically.
  typedef enum logic [1:0] {
    OCCR_NT     = 2'b00,
    OCCR_T      = 2'b01,
    OCCR_PRED   = 2'b10,
    OCCR_PRED_X = 2'b11
  } occr_e;

  localparam int unsigned MISPRED_CNT_W = 32;

  // One saturating step of a counter of 'width' bits (1..4), carried in a
  // 4-bit container so callers of any width can share it.
  function automatic logic [3:0] ctr_next(input logic [3:0] ctr,
                                          input logic       taken,
                                          input int unsigned width = 4);
    logic [3:0] ctr_max;
    ctr_max = 4'((5'd1 << width) - 5'd1);
    if (taken) begin
      return (ctr >= ctr_max) ? ctr : ctr + 4'd1;
    end
    return (ctr == 4'd0) ? ctr : ctr - 4'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One saturating direction counter of the prediction table.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk,
  input  logic             rstn_h,
  input  logic             en,
  input  logic             taken,
  output logic [CTR_W-1:0] state
);

  // Weakly not-taken: one below the taken threshold (0 for a 1-bit counter).
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'((1 << (CTR_W - 1)) - 1);

  // Step toward the resolved direction when this entry is selected.
  always_ff @(posedge clk or negedge rstn_h) begin
    if (!rstn_h) begin
      state <= CTR_RST;
    end else if (en) begin
      state <= CTR_W'(ctr_next(4'(state), taken, CTR_W));
    end
  end

endmodule

// File: rtl/branch_pred_table.sv
// Bimodal / gshare branch predictor: counter table, index hash, global
// history, combinational read mux and a saturating mispredict counter.
module branch_pred_table
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned HIST_W  = 0,
  parameter int unsigned PC_W    = 32,
  localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
  input  logic                     clk,
  input  logic                     rstn_h,
  input  logic [PC_W-1:0]          lookup_pc,
  input  logic [1:0]               branch_occr,
  output logic                     branch_taken,
  output logic [IDX_W-1:0]         pred_idx,
  input  logic                     upd_valid,
  input  logic [IDX_W-1:0]         upd_idx,
  input  logic                     upd_taken,
  input  logic                     upd_mispred,
  output logic [MISPRED_CNT_W-1:0] mispred_cnt
);

  logic [IDX_W-1:0]         hist_ext;
  logic [CTR_W-1:0]         ctr_state [ENTRIES];
  logic [MISPRED_CNT_W-1:0] mispred_q;
  logic                     unused_pc;

  // Only the word-aligned index slice of the PC participates in the hash.
  assign unused_pc = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};

  generate
    if (HIST_W > 0) begin : g_ghr
      logic [HIST_W-1:0] ghr;

      // History shifts in resolved directions only (non-speculative).
      always_ff @(posedge clk or negedge rstn_h) begin
        if (!rstn_h) begin
          ghr <= '0;
        end else if (upd_valid) begin
          if (HIST_W == 1) begin
            ghr <= HIST_W'(upd_taken);
          end else begin
            ghr <= HIST_W'({ghr, upd_taken});
          end
        end
      end

      assign hist_ext = IDX_W'(ghr);
    end else begin : g_no_ghr
      assign hist_ext = '0;
    end
  endgenerate

  assign pred_idx = lookup_pc[IDX_W+1:2] ^ hist_ext;

  generate
    for (genvar i = 0; i < int'(ENTRIES); i++) begin : g_ctr
      bp_sat_counter #(
        .CTR_W (CTR_W)
      ) u_ctr (
        .clk    (clk),
        .rstn_h (rstn_h),
        .en     (upd_valid && (upd_idx == IDX_W'(i))),
        .taken  (upd_taken),
        .state  (ctr_state[i])
      );
    end
  endgenerate

  // Read mux: table MSB in predict mode, otherwise the forced direction.
  always_comb begin
    branch_taken = branch_occr[0];
    if (branch_occr[1]) begin
      branch_taken = ctr_state[pred_idx][CTR_W-1];
    end
  end

  // Mispredict counter for performance monitoring, sticks at all-ones.
  always_ff @(posedge clk or negedge rstn_h) begin
    if (!rstn_h) begin
      mispred_q <= '0;
    end else if (upd_valid && upd_mispred && (mispred_q != '1)) begin
      mispred_q <= mispred_q + 1'b1;
    end
  end

  assign mispred_cnt = mispred_q;

endmodule

// File: tb/tb_branch_pred_table.sv
// Scoreboard bench for branch_pred_table: a bimodal instance (64 entries)
// and a gshare instance (16 entries, 4-bit history) share one stimulus stream.
module tb_branch_pred_table;
  import bp_pkg::*;

  logic        clk;
  logic        rstn_h;
  logic [31:0] lookup_pc;
  logic [1:0]  branch_occr;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic        upd_taken;
  logic        upd_mispred;

  logic        branch_taken, branch_taken_g;
  logic [5:0]  pred_idx;
  logic [3:0]  pred_idx_g;
  logic [31:0] mispred_cnt, mispred_cnt_g;
  logic [3:0]  upd_idx_g;

  assign upd_idx_g = upd_idx[3:0];

  branch_pred_table dut (
    .clk          (clk),
    .rstn_h       (rstn_h),
    .lookup_pc    (lookup_pc),
    .branch_occr  (branch_occr),
    .branch_taken (branch_taken),
    .pred_idx     (pred_idx),
    .upd_valid    (upd_valid),
    .upd_idx      (upd_idx),
    .upd_taken    (upd_taken),
    .upd_mispred  (upd_mispred),
    .mispred_cnt  (mispred_cnt)
  );

  branch_pred_table #(.ENTRIES(16), .HIST_W(4)) dut_g (
    .clk          (clk),
    .rstn_h       (rstn_h),
    .lookup_pc    (lookup_pc),
    .branch_occr  (branch_occr),
    .branch_taken (branch_taken_g),
    .pred_idx     (pred_idx_g),
    .upd_valid    (upd_valid),
    .upd_idx      (upd_idx_g),
    .upd_taken    (upd_taken),
    .upd_mispred  (upd_mispred),
    .mispred_cnt  (mispred_cnt_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [1:0]  m_ctr  [64];
  logic [1:0]  g_ctr  [16];
  logic [3:0]  m_ghr;
  logic [31:0] m_mp, g_mp;

  typedef struct {
    logic       tk;
    logic [5:0] idx;
    logic       gtk;
    logic [3:0] gidx;
  } exp_t;
  exp_t sb[$];

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? c : c + 2'd1;
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 2'd1;
    for (int i = 0; i < 16; i++) g_ctr[i] = 2'd1;
    m_ghr = 4'd0;
    m_mp  = 32'd0;
    g_mp  = 32'd0;
  endtask

  // One cycle: drive at negedge, check lookup outputs, then check state after the edge.
  task automatic step(input logic [31:0] pc, input occr_e occr, input logic uv,
                      input logic [5:0] uidx, input logic ut, input logic um);
    exp_t e, o;
    lookup_pc   = pc;
    branch_occr = occr;
    upd_valid   = uv;
    upd_idx     = uidx;
    upd_taken   = ut;
    upd_mispred = um;
    e.idx  = pc[7:2];
    e.gidx = pc[5:2] ^ m_ghr;
    e.tk   = occr[1] ? m_ctr[e.idx][1]  : occr[0];
    e.gtk  = occr[1] ? g_ctr[e.gidx][1] : occr[0];
    sb.push_back(e);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      o = sb.pop_front();
      chk("taken",    {31'd0, branch_taken},   {31'd0, o.tk});
      chk("idx",      {26'd0, pred_idx},       {26'd0, o.idx});
      chk("taken_g",  {31'd0, branch_taken_g}, {31'd0, o.gtk});
      chk("idx_g",    {28'd0, pred_idx_g},     {28'd0, o.gidx});
    end
    @(posedge clk);
    if (rstn_h && uv) begin
      m_ctr[uidx]      = sat_step(m_ctr[uidx], ut);
      g_ctr[uidx[3:0]] = sat_step(g_ctr[uidx[3:0]], ut);
      m_ghr = {m_ghr[2:0], ut};
      if (um && m_mp != 32'hffff_ffff) m_mp = m_mp + 32'd1;
      if (um && g_mp != 32'hffff_ffff) g_mp = g_mp + 32'd1;
    end
    #1;
    chk("mispred",   mispred_cnt,   m_mp);
    chk("mispred_g", mispred_cnt_g, g_mp);
    @(negedge clk);
  endtask

  task automatic reset_cycle();
    rstn_h = 1'b0;
    model_reset();
    step(32'h0000_0040, OCCR_PRED, 1'b1, 6'd3, 1'b1, 1'b1);
    rstn_h = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn_h = 1'b0;
    lookup_pc = '0; branch_occr = OCCR_PRED; upd_valid = 1'b0;
    upd_idx = '0; upd_taken = 1'b0; upd_mispred = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset: table reads weakly not-taken everywhere, updates discarded.
    step(32'h1234_5678, OCCR_PRED,   1'b1, 6'd22, 1'b1, 1'b1);
    step(32'hffff_fffc, OCCR_PRED_X, 1'b0, 6'd0,  1'b0, 1'b0);
    chk("rst_ctr0", {30'd0, dut.g_ctr[0].u_ctr.state}, 32'd1);
    chk("rst_ghr",  {28'd0, dut_g.g_ghr.ghr},          32'd0);
    rstn_h = 1'b1;

    // Forced modes
    step(32'h0000_0014, OCCR_T,  1'b0, 6'd0, 1'b0, 1'b0);
    step(32'h0000_0014, OCCR_NT, 1'b0, 6'd0, 1'b0, 1'b0);

    // Saturation at idx 5
    for (int i = 0; i < 4; i++) step(32'h0000_0014, OCCR_PRED, 1'b1, 6'd5, 1'b1, 1'b0);
    chk("ctr5_hi", {30'd0, dut.g_ctr[5].u_ctr.state}, {30'd0, m_ctr[5]});
    step(32'h0000_0014, OCCR_PRED, 1'b1, 6'd5, 1'b0, 1'b0);
    step(32'h0000_0014, OCCR_PRED, 1'b0, 6'd5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(32'h0000_0014, OCCR_PRED, 1'b1, 6'd5, 1'b0, 1'b0);
    chk("ctr5_lo", {30'd0, dut.g_ctr[5].u_ctr.state}, {30'd0, m_ctr[5]});

    // Same-cycle hazard at idx 7, then back-to-back updates at idx 9
    step(32'h0000_001c, OCCR_PRED, 1'b1, 6'd7, 1'b1, 1'b0);
    step(32'h0000_001c, OCCR_PRED, 1'b0, 6'd7, 1'b0, 1'b0);
    step(32'h0000_0024, OCCR_PRED, 1'b1, 6'd9, 1'b1, 1'b0);
    step(32'h0000_0024, OCCR_PRED, 1'b1, 6'd9, 1'b1, 1'b0);
    chk("ctr9", {30'd0, dut.g_ctr[9].u_ctr.state}, {30'd0, m_ctr[9]});

    // gshare history pattern T,T,NT,T then lookup at 0x8
    reset_cycle();
    step(32'h0000_0008, OCCR_PRED, 1'b1, 6'd1, 1'b1, 1'b0);
    step(32'h0000_0008, OCCR_PRED, 1'b1, 6'd2, 1'b1, 1'b0);
    step(32'h0000_0008, OCCR_PRED, 1'b1, 6'd3, 1'b0, 1'b0);
    step(32'h0000_0008, OCCR_PRED, 1'b1, 6'd4, 1'b1, 1'b0);
    chk("ghr", {28'd0, dut_g.g_ghr.ghr}, {28'd0, m_ghr});
    step(32'h0000_0008, OCCR_PRED, 1'b0, 6'd0, 1'b0, 1'b0);

    // Perf counter: 3 qualified mispredicts, 1 unqualified
    reset_cycle();
    for (int i = 0; i < 3; i++) step(32'h0000_0100, OCCR_PRED, 1'b1, 6'd12, 1'b0, 1'b1);
    step(32'h0000_0100, OCCR_PRED, 1'b0, 6'd12, 1'b1, 1'b1);
    chk("mp3", mispred_cnt, 32'd3);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      step($urandom, occr_e'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Mid-stream reset drops everything, including the update at that edge
    reset_cycle();
    step(32'h0000_0014, OCCR_PRED, 1'b0, 6'd0, 1'b0, 1'b0);

    // Perf counter saturation from a preloaded all-ones value
    force dut.mispred_q = 32'hffff_ffff;
    #1;
    release dut.mispred_q;
    m_mp = 32'hffff_ffff;
    step(32'h0000_0000, OCCR_PRED, 1'b1, 6'd0, 1'b0, 1'b1);
    step(32'h0000_0000, OCCR_PRED, 1'b1, 6'd0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
